// File: rtl/rice_core_mul_ctrl.sv
// Execute-stage sequencer in front of the iterative multiplier: holds one request, drives the
// multiplier handshake, and hands the result to writeback. Optional cache: RICE_CORE_MUL_RESULT_CACHE_EN.

package rice_core_pkg;
    typedef struct packed {
        logic mul;
        logic mulh;
        logic mulhsu;
        logic mulhu;
    } rice_core_mul_operation;
endpackage

module rice_core_mul_ctrl
    import rice_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [XLEN-1:0]        i_rs1_value,
    input  logic [XLEN-1:0]        i_rs2_value,
    input  rice_core_mul_operation i_mul_operation,
    input  logic [4:0]             i_rd,
    output logic                   o_mul_valid,
    output logic [XLEN-1:0]        o_mul_rs1_value,
    output logic [XLEN-1:0]        o_mul_rs2_value,
    output rice_core_mul_operation o_mul_operation,
    input  logic                   i_mul_result_valid,
    input  logic [XLEN-1:0]        i_mul_result,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_result,
    output logic [4:0]             o_rd
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        DRAIN
    } state_t;

    state_t state;

    assign o_ready = (state == IDLE) && !i_flush;

`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
    logic                   cache_valid;
    logic [XLEN-1:0]        cache_rs1;
    logic [XLEN-1:0]        cache_rs2;
    logic [XLEN-1:0]        cache_result;
    rice_core_mul_operation cache_operation;
    logic                   cache_hit;

    assign cache_hit = cache_valid
                    && (i_rs1_value == cache_rs1)
                    && (i_rs2_value == cache_rs2)
                    && (i_mul_operation == cache_operation);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            o_mul_valid     <= 1'b0;
            o_valid         <= 1'b0;
            o_mul_rs1_value <= '0;
            o_mul_rs2_value <= '0;
            o_mul_operation <= '0;
            o_result        <= '0;
            o_rd            <= '0;
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
            cache_valid     <= 1'b0;
            cache_rs1       <= '0;
            cache_rs2       <= '0;
            cache_result    <= '0;
            cache_operation <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        o_mul_rs1_value <= i_rs1_value;
                        o_mul_rs2_value <= i_rs2_value;
                        o_mul_operation <= i_mul_operation;
                        o_rd            <= i_rd;
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
                        if (cache_hit) begin
                            o_result <= cache_result;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            o_mul_valid <= 1'b1;
                            state       <= BUSY;
                        end
`else
                        o_mul_valid <= 1'b1;
                        state       <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    // The multiplier counter only rewinds on its final cycle, so a
                    // flush must let it finish (DRAIN) unless it finishes right now.
                    if (i_flush) begin
                        if (i_mul_result_valid) begin
                            o_mul_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (i_mul_result_valid) begin
                        o_result    <= i_mul_result;
                        o_mul_valid <= 1'b0;
                        o_valid     <= 1'b1;
                        state       <= DONE;
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
                        cache_valid     <= 1'b1;
                        cache_rs1       <= o_mul_rs1_value;
                        cache_rs2       <= o_mul_rs2_value;
                        cache_operation <= o_mul_operation;
                        cache_result    <= i_mul_result;
`endif
                    end
                end
                DONE: begin
                    if (i_flush || i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (i_mul_result_valid) begin
                        o_mul_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_mul_valid <= 1'b0;
                    o_valid     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_core_mul_ctrl.sv
// Scoreboard bench for rice_core_mul_ctrl with a variable-latency multiplier model.
// Cache expectations follow RICE_CORE_MUL_RESULT_CACHE_EN.

module tb_rice_core_mul_ctrl;
    import rice_core_pkg::*;

    localparam rice_core_mul_operation OP_MUL    = 4'b1000;
    localparam rice_core_mul_operation OP_MULH   = 4'b0100;
    localparam rice_core_mul_operation OP_MULHSU = 4'b0010;
    localparam rice_core_mul_operation OP_MULHU  = 4'b0001;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [31:0]            rs1 = '0;
    logic [31:0]            rs2 = '0;
    rice_core_mul_operation op = '0;
    logic [4:0]             rd = '0;
    logic                   mul_valid;
    logic [31:0]            mul_rs1;
    logic [31:0]            mul_rs2;
    rice_core_mul_operation mul_op;
    logic                   mul_result_valid;
    logic [31:0]            mul_result;
    logic                   res_valid;
    logic                   wb_ready = 1'b1;
    logic [31:0]            result;
    logic [4:0]             res_rd;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rice_core_mul_ctrl #(.XLEN(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_flush            (flush),
        .i_valid            (req_valid),
        .o_ready            (req_ready),
        .i_rs1_value        (rs1),
        .i_rs2_value        (rs2),
        .i_mul_operation    (op),
        .i_rd               (rd),
        .o_mul_valid        (mul_valid),
        .o_mul_rs1_value    (mul_rs1),
        .o_mul_rs2_value    (mul_rs2),
        .o_mul_operation    (mul_op),
        .i_mul_result_valid (mul_result_valid),
        .i_mul_result       (mul_result),
        .o_valid            (res_valid),
        .i_ready            (wb_ready),
        .o_result           (result),
        .o_rd               (res_rd)
    );

    // RISC-V M-extension semantics from full-width products.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input rice_core_mul_operation o);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        if (o.mulh)        p = 64'(sa * sb);
        else if (o.mulhsu) p = 64'(sa * ub);
        else               p = {32'b0, a} * {32'b0, b};
        return o.mul ? p[31:0] : p[63:32];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model: result pulses on the lat-th cycle of i_valid; latency latched per iteration.
    int unsigned lat_next = 6;
    int unsigned lat_cur = 6;
    int unsigned lat_eff;
    int unsigned cnt = 0;
    logic [31:0] junk = '0;

    assign lat_eff          = (cnt == 0) ? lat_next : lat_cur;
    assign mul_result_valid = mul_valid && (cnt == lat_eff - 1);
    assign mul_result       = mul_result_valid ? ref_mul(mul_rs1, mul_rs2, mul_op) : junk;

    always @(posedge clk) begin
        junk <= $urandom;
        if (rst) begin
            cnt <= 0;
        end else if (mul_valid) begin
            if (cnt == 0) lat_cur <= lat_next;
            cnt <= mul_result_valid ? 0 : cnt + 1;
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0]            a;
        logic [31:0]            b;
        rice_core_mul_operation o;
        logic [31:0]            res;
        logic [4:0]             tag;
        int                     due;
        bit                     seen;
    } exp_t;

    exp_t exp_q[$];
    bit   prev_rv = 1'b0;

`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
    bit                     c_ok = 1'b0;
    logic [31:0]            c_a, c_b, c_res;
    rice_core_mul_operation c_op;
`endif

    task automatic retire(input exp_t e);
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
        // A completion at or before this cycle was kept, so it refreshed the cache.
        if (cyc >= e.due) begin
            c_ok = 1'b1; c_a = e.a; c_b = e.b; c_op = e.o; c_res = e.res;
        end
`endif
        exp_q.pop_front();
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   hit;
        if (rst) begin
            exp_q.delete();
            prev_rv = 1'b0;
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
            c_ok = 1'b0;
`endif
        end else begin
            if (prev_rv) cmp("mul_valid_drop", 32'(mul_valid), 32'd0);
            prev_rv = mul_result_valid;
            if (flush && exp_q.size() > 0) begin
                retire(exp_q[0]);
            end else if (res_valid) begin
                if (exp_q.size() == 0) begin
                    cmp("spurious_valid", 32'(res_valid), 32'd0);
                end else begin
                    if (!exp_q[0].seen) begin
                        cmp("latency", 32'(cyc), 32'(exp_q[0].due));
                        exp_q[0].seen = 1'b1;
                    end
                    cmp("result", result, exp_q[0].res);
                    cmp("rd", 32'(res_rd), 32'(exp_q[0].tag));
                    if (wb_ready) retire(exp_q[0]);
                end
            end else if (exp_q.size() > 0 && exp_q[0].seen) begin
                cmp("valid_dropped", 32'(res_valid), 32'd1);
                exp_q.pop_front();
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                cmp("result_timeout", 32'(res_valid), 32'd1);
                exp_q.pop_front();
            end
            if (req_valid && req_ready) begin
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
                hit = c_ok && c_a == rs1 && c_b == rs2 && c_op == op;
`else
                hit = 1'b0;
`endif
                e.a = rs1; e.b = rs2; e.o = op; e.tag = rd;
                e.res  = ref_mul(rs1, rs2, op);
                e.due  = cyc + (hit ? 1 : int'(lat_next) + 1);
                e.seen = 1'b0;
                exp_q.push_back(e);
            end
        end
    end

    // Directed stimulus helpers; issue returns at the start of cycle T+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input rice_core_mul_operation o, input logic [4:0] t);
        bit ok = 1'b0;
        @(posedge clk); #1;
        rs1 = a; rs2 = b; op = o; rd = t; req_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) cmp("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) cmp(name, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input rice_core_mul_operation o, input logic [4:0] t,
                          input logic [31:0] exp);
        bit ok = 1'b0;
        issue(a, b, o, t);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        if (ok) cmp(name, result, exp);
        else    cmp({name, "_timeout"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    bit cache_on;
    logic [31:0] held_res;
    logic [4:0]  held_rd;

    initial begin
`ifdef RICE_CORE_MUL_RESULT_CACHE_EN
        cache_on = 1'b1;
`else
        cache_on = 1'b0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_mul_valid", 32'(mul_valid), 32'd0);
        cmp("rst_valid", 32'(res_valid), 32'd0);
        cmp("rst_ready", 32'(req_ready), 32'd1);
        cmp("rst_result", result, 32'd0);
        cmp("rst_mul_rs1", mul_rs1, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // MUL 7x6 cycle-accurate
        issue(32'd7, 32'd6, OP_MUL, 5'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 6) cmp("t1_mul_valid_hi", 32'(mul_valid), 32'd1);
            if (k == 7) begin
                cmp("t1_mul_valid_lo", 32'(mul_valid), 32'd0);
                cmp("t1_valid", 32'(res_valid), 32'd1);
                cmp("t1_result", result, 32'h0000_002A);
                cmp("t1_rd", 32'(res_rd), 32'd5);
                cmp("t1_ready_done", 32'(req_ready), 32'd0);
            end
            if (k == 8) cmp("t1_ready_idle", 32'(req_ready), 32'd1);
        end

        run_op("mulh", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULH, 5'd1, 32'h0000_0000);
        run_op("mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHU, 5'd2, 32'hFFFF_FFFE);
        run_op("mulhsu", 32'hFFFF_FFFF, 32'h0000_0002, OP_MULHSU, 5'd3, 32'hFFFF_FFFF);

        // Back-pressure in DONE
        wb_ready = 1'b0;
        issue(32'd11, 32'd13, OP_MUL, 5'd3);
        wait_done("bp_timeout");
        held_res = result;
        held_rd  = res_rd;
        for (int k = 0; k < 2; k++) begin
            cmp("bp_valid", 32'(res_valid), 32'd1);
            cmp("bp_result", held_res, 32'h0000_008F);
            cmp("bp_rd_stable", 32'(res_rd), 32'(held_rd));
            cmp("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        cmp("bp_result_stable", result, held_res);
        @(posedge clk); #1 wb_ready = 1'b1;
        @(negedge clk);
        cmp("bp_ready_hold", 32'(req_ready), 32'd0);
        @(negedge clk);
        cmp("bp_ready_after", 32'(req_ready), 32'd1);
        cmp("bp_valid_after", 32'(res_valid), 32'd0);

        // Flush at T+3 drains the multiplier
        issue(32'd9, 32'd9, OP_MUL, 5'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        cmp("fl_ready_blocked", 32'(req_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            cmp("fl_no_valid", 32'(res_valid), 32'd0);
            if (k == 6) cmp("fl_mul_valid_t6", 32'(mul_valid), 32'd1);
            if (k == 7) begin
                cmp("fl_mul_valid_t7", 32'(mul_valid), 32'd0);
                cmp("fl_ready_t7", 32'(req_ready), 32'd1);
            end
        end
        run_op("after_flush", 32'd3, 32'd5, OP_MUL, 5'd8, 32'h0000_000F);

        // Reset mid-iteration
        issue(32'd100, 32'd3, OP_MUL, 5'd9);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        cmp("mr_mul_valid", 32'(mul_valid), 32'd0);
        cmp("mr_valid", 32'(res_valid), 32'd0);
        cmp("mr_ready", 32'(req_ready), 32'd1);
        cmp("mr_result", result, 32'd0);
        cmp("mr_rd", 32'(res_rd), 32'd0);
        cmp("mr_mul_rs1", mul_rs1, 32'd0);
        run_op("after_rst", 32'd2, 32'd2, OP_MUL, 5'd10, 32'h0000_0004);

        // Repeat request: cache hit when enabled, full path otherwise
        run_op("c_first", 32'd7, 32'd6, OP_MUL, 5'd11, 32'h0000_002A);
        issue(32'd7, 32'd6, OP_MUL, 5'd12);
        @(negedge clk);
        cmp("c_repeat_valid", 32'(res_valid), 32'(cache_on));
        cmp("c_repeat_mul_valid", 32'(mul_valid), 32'(!cache_on));
        if (cache_on) cmp("c_repeat_result", result, 32'h0000_002A);
        wait_done("c_repeat_timeout");
        issue(32'd7, 32'd5, OP_MUL, 5'd13);
        @(negedge clk);
        cmp("c_miss_valid", 32'(res_valid), 32'd0);
        cmp("c_miss_mul_valid", 32'(mul_valid), 32'd1);
        wait_done("c_miss_timeout");

        // Randomised traffic: back-pressure, flushes, varying multiplier latency
        begin
            int          issued = 0;
            bit          acc;
            logic [31:0] la = 32'd1, lb = 32'd1;
            rice_core_mul_operation lo = OP_MUL;
            for (int c = 0; c < 4000 && issued < 80; c++) begin
                @(negedge clk);
                acc = req_valid && req_ready;
                @(posedge clk); #1;
                if (acc) begin
                    issued++;
                    req_valid = 1'b0;
                end else if (!req_valid && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        la = pick_operand();
                        lb = pick_operand();
                        lo = rice_core_mul_operation'(4'(1 << $urandom_range(0, 3)));
                    end
                    lat_next  = $urandom_range(1, 8);
                    rs1 = la; rs2 = lb; op = lo;
                    rd  = 5'($urandom_range(0, 31));
                    req_valid = 1'b1;
                end
                wb_ready = ($urandom_range(0, 3) != 0);
                flush    = ($urandom_range(0, 19) == 0);
            end
            req_valid = 1'b0;
            flush     = 1'b0;
            wb_ready  = 1'b1;
            repeat (20) @(negedge clk);
            cmp("rand_issued", 32'(issued), 32'd80);
            cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
